// File: rtl/ic1337_seq_detector_if.sv
// Bundles the ic1337 sample inputs and the detector status outputs.
// IC1337_DET_STICKY_EN adds the sticky match_seen flag.
interface ic1337_seq_detector_if #(
  parameter int unsigned CNT_W = 8
);
  logic             sample_en;
  logic             clr;
  logic             Q0;
  logic             Q1;
  logic             Z;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] z_count;
  logic [CNT_W-1:0] z_run;
  logic [CNT_W-1:0] z_max;
`ifdef IC1337_DET_STICKY_EN
  logic             match_seen;

  modport master (
    output sample_en, clr, Q0, Q1, Z,
    input  match, match_cnt, z_count, z_run, z_max, match_seen
  );
  modport slave (
    input  sample_en, clr, Q0, Q1, Z,
    output match, match_cnt, z_count, z_run, z_max, match_seen
  );
`else
  modport master (
    output sample_en, clr, Q0, Q1, Z,
    input  match, match_cnt, z_count, z_run, z_max
  );
  modport slave (
    input  sample_en, clr, Q0, Q1, Z,
    output match, match_cnt, z_count, z_run, z_max
  );
`endif
endinterface

// File: rtl/ic1337_seq_detector.sv
// Detects {Q1,Q0} = 00 -> 10 -> 01 on enabled edges and keeps saturating Z-high statistics.
// IC1337_DET_STICKY_EN adds a sticky match_seen flag cleared only by rst/clr.
module ic1337_seq_detector #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ic1337_seq_detector_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_A    = 2'd1,
    S_B    = 2'd2
  } state_e;

  state_e           state_q;
  logic             match_q;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] z_count_q, z_count_d;
  logic [CNT_W-1:0] z_run_q, z_run_d;
  logic [CNT_W-1:0] z_max_q, z_max_d;
  logic [1:0]       sym;
  logic             hit;

  assign sym = {bus.Q1, bus.Q0};
  assign hit = (state_q == S_B) && (sym == 2'b01);

  // Saturating next values, applied only on enabled edges.
  always_comb begin
    z_count_d   = z_count_q;
    z_run_d     = '0;
    match_cnt_d = match_cnt_q;
    if (bus.Z) begin
      z_count_d = (z_count_q == CNT_MAX) ? z_count_q : z_count_q + CNT_ONE;
      z_run_d   = (z_run_q == CNT_MAX) ? z_run_q : z_run_q + CNT_ONE;
    end
    z_max_d = (z_run_d > z_max_q) ? z_run_d : z_max_q;
    if (hit && (match_cnt_q != CNT_MAX)) begin
      match_cnt_d = match_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      state_q     <= S_IDLE;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
      z_count_q   <= '0;
      z_run_q     <= '0;
      z_max_q     <= '0;
    end else if (!bus.sample_en) begin
      match_q <= 1'b0;
    end else begin
      match_q     <= hit;
      match_cnt_q <= match_cnt_d;
      z_count_q   <= z_count_d;
      z_run_q     <= z_run_d;
      z_max_q     <= z_max_d;
      // A 00 always restarts the pattern, which covers every overlap.
      case (state_q)
        S_IDLE:  state_q <= (sym == 2'b00) ? S_A : S_IDLE;
        S_A: begin
          if (sym == 2'b00)      state_q <= S_A;
          else if (sym == 2'b10) state_q <= S_B;
          else                   state_q <= S_IDLE;
        end
        S_B:     state_q <= (sym == 2'b00) ? S_A : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.z_count   = z_count_q;
  assign bus.z_run     = z_run_q;
  assign bus.z_max     = z_max_q;

`ifdef IC1337_DET_STICKY_EN
  logic match_seen_q;

  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      match_seen_q <= 1'b0;
    end else if (bus.sample_en && hit) begin
      match_seen_q <= 1'b1;
    end
  end

  assign bus.match_seen = match_seen_q;
`endif

endmodule

// File: tb/tb_ic1337_seq_detector.sv
// Self-checking bench for ic1337_seq_detector (CNT_W=4) against a symbol-history reference model.
module tb_ic1337_seq_detector;

  localparam int unsigned CNT_W = 4;
  localparam int          SAT   = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ic1337_seq_detector_if #(.CNT_W(CNT_W)) bus ();

  ic1337_seq_detector #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: last three enabled symbols since reset/clr plus plain counters.
  int         m_match, m_mcnt, m_zcnt, m_zrun, m_zmax, m_seen;
  logic [1:0] h0, h1, h2;

  task automatic model_clear();
    m_match = 0; m_mcnt = 0; m_zcnt = 0; m_zrun = 0; m_zmax = 0; m_seen = 0;
    h0 = 2'b11; h1 = 2'b11; h2 = 2'b11;
  endtask

  task automatic step(input logic r, input logic c, input logic en,
                      input logic [1:0] s, input logic z);
    rst = r; bus.clr = c; bus.sample_en = en;
    bus.Q1 = s[1]; bus.Q0 = s[0]; bus.Z = z;
    @(posedge clk);
    if (r || c) begin
      model_clear();
    end else if (!en) begin
      m_match = 0;
    end else begin
      h0 = h1; h1 = h2; h2 = s;
      m_match = (h0 == 2'b00 && h1 == 2'b10 && h2 == 2'b01) ? 1 : 0;
      if (m_match == 1) begin
        m_mcnt = (m_mcnt < SAT) ? m_mcnt + 1 : SAT;
        m_seen = 1;
      end
      if (z) begin
        m_zcnt = (m_zcnt < SAT) ? m_zcnt + 1 : SAT;
        m_zrun = (m_zrun < SAT) ? m_zrun + 1 : SAT;
      end else begin
        m_zrun = 0;
      end
      if (m_zrun > m_zmax) m_zmax = m_zrun;
    end
    #1;
  endtask

  task automatic test_reset();
    model_clear();
    for (int i = 0; i < 2; i++) step(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
    checks++;
    if (bus.match !== 1'b0) begin errors++; $display("FAIL reset_match got %0d exp 0", bus.match); end
    checks++;
    if (bus.match_cnt !== 4'd0) begin errors++; $display("FAIL reset_match_cnt got %0d exp 0", bus.match_cnt); end
    checks++;
    if (bus.z_count !== 4'd0 || bus.z_run !== 4'd0 || bus.z_max !== 4'd0) begin
      errors++; $display("FAIL reset_z got %0d/%0d/%0d exp 0/0/0", bus.z_count, bus.z_run, bus.z_max);
    end
    step(1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
    checks++;
    if (bus.z_count !== 4'd1 || bus.z_run !== 4'd1) begin
      errors++; $display("FAIL reset_first_sample got %0d/%0d exp 1/1", bus.z_count, bus.z_run);
    end
  endtask

  task automatic test_basic_match();
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    checks++;
    if (bus.match !== 1'b0) begin errors++; $display("FAIL basic_early got %0d exp 0", bus.match); end
    step(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    checks++;
    if (bus.match !== 1'b1 || bus.match_cnt !== 4'd1) begin
      errors++; $display("FAIL basic_match got %0d cnt %0d exp 1 cnt 1", bus.match, bus.match_cnt);
    end
    step(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    checks++;
    if (bus.match !== 1'b0 || bus.match_cnt !== 4'd1) begin
      errors++; $display("FAIL basic_after got %0d cnt %0d exp 0 cnt 1", bus.match, bus.match_cnt);
    end
  endtask

  task automatic test_overlap_gaps();
    int pulses;
    logic [1:0] seq [9];
    logic       en  [9];
    seq = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b11, 2'b01};
    en  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    pulses = 0;
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, en[i], seq[i], 1'b0);
      if (bus.match === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 2) begin errors++; $display("FAIL overlap_pulses got %0d exp 2", pulses); end
    checks++;
    if (bus.match !== 1'b1 || bus.match_cnt !== 4'd2) begin
      errors++; $display("FAIL overlap_gap_match got %0d cnt %0d exp 1 cnt 2", bus.match, bus.match_cnt);
    end
  endtask

  task automatic test_z_stats();
    logic zs [6];
    zs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    foreach (zs[i]) step(1'b0, 1'b0, 1'b1, 2'b11, zs[i]);
    checks++;
    if (bus.z_count !== 4'd5 || bus.z_run !== 4'd2 || bus.z_max !== 4'd3) begin
      errors++; $display("FAIL z_stats got %0d/%0d/%0d exp 5/2/3", bus.z_count, bus.z_run, bus.z_max);
    end
    step(1'b0, 1'b1, 1'b1, 2'b11, 1'b1);
    checks++;
    if (bus.z_count !== 4'd0 || bus.z_run !== 4'd0 || bus.z_max !== 4'd0 || bus.match_cnt !== 4'd0) begin
      errors++; $display("FAIL z_clr got %0d/%0d/%0d cnt %0d exp 0/0/0 cnt 0",
                         bus.z_count, bus.z_run, bus.z_max, bus.match_cnt);
    end
  endtask

  task automatic test_saturation();
    int wraps;
    wraps = 0;
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
      if (bus.z_count !== 4'((i < SAT) ? i + 1 : SAT)) wraps++;
    end
    checks++;
    if (wraps != 0) begin errors++; $display("FAIL sat_z_track got %0d bad steps exp 0", wraps); end
    checks++;
    if (bus.z_count !== 4'd15 || bus.z_run !== 4'd15 || bus.z_max !== 4'd15) begin
      errors++; $display("FAIL sat_z got %0d/%0d/%0d exp 15/15/15", bus.z_count, bus.z_run, bus.z_max);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
      step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
      step(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    end
    checks++;
    if (bus.match_cnt !== 4'd15 || bus.match !== 1'b1) begin
      errors++; $display("FAIL sat_match_cnt got %0d match %0d exp 15 match 1", bus.match_cnt, bus.match);
    end
    checks++;
    if (bus.z_max !== 4'd15) begin errors++; $display("FAIL sat_zmax_hold got %0d exp 15", bus.z_max); end
  endtask

  task automatic test_abort_sticky();
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    checks++;
    if (bus.match !== 1'b0 || bus.match_cnt !== 4'd0) begin
      errors++; $display("FAIL abort got %0d cnt %0d exp 0 cnt 0", bus.match, bus.match_cnt);
    end
`ifdef IC1337_DET_STICKY_EN
    checks++;
    if (bus.match_seen !== 1'b0) begin errors++; $display("FAIL sticky_init got %0d exp 0", bus.match_seen); end
    step(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom));
    checks++;
    if (bus.match_seen !== 1'b1) begin errors++; $display("FAIL sticky_hold got %0d exp 1", bus.match_seen); end
    step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    checks++;
    if (bus.match_seen !== 1'b0) begin errors++; $display("FAIL sticky_clr got %0d exp 0", bus.match_seen); end
`endif
  endtask

  task automatic test_random();
    logic [1:0] pick [3];
    logic [1:0] s;
    logic       r, c, en;
    pick = '{2'b00, 2'b10, 2'b01};
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      c  = ($urandom_range(0, 49) == 0);
      en = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 4) == 0) ? 2'b11 : pick[$urandom_range(0, 2)];
      step(r, c, en, s, ($urandom_range(0, 3) != 0));
      checks++;
      if (bus.match !== 1'(m_match) || bus.match_cnt !== 4'(m_mcnt)) begin
        errors++; $display("FAIL rand_match step %0d got %0d cnt %0d exp %0d cnt %0d",
                           i, bus.match, bus.match_cnt, m_match, m_mcnt);
      end
      checks++;
      if (bus.z_count !== 4'(m_zcnt) || bus.z_run !== 4'(m_zrun) || bus.z_max !== 4'(m_zmax)) begin
        errors++; $display("FAIL rand_z step %0d got %0d/%0d/%0d exp %0d/%0d/%0d",
                           i, bus.z_count, bus.z_run, bus.z_max, m_zcnt, m_zrun, m_zmax);
      end
`ifdef IC1337_DET_STICKY_EN
      checks++;
      if (bus.match_seen !== 1'(m_seen)) begin
        errors++; $display("FAIL rand_seen step %0d got %0d exp %0d", i, bus.match_seen, m_seen);
      end
`endif
    end
  endtask

  initial begin
    bus.sample_en = 1'b0; bus.clr = 1'b0; bus.Q0 = 1'b0; bus.Q1 = 1'b0; bus.Z = 1'b0;
    test_reset();
    test_basic_match();
    test_overlap_gaps();
    test_z_stats();
    test_saturation();
    test_abort_sticky();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
